param_tlb_mmu: RTL

PARAM_TLB_MMU -- requirements
Module: param_tlb_mmu

---
 rtl/param_tlb_mmu_if.sv | 73 +++++++
 rtl/param_tlb_mmu.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_tlb_mmu_if.sv
// -----------------------------------------------------------------------------
// param_tlb_mmu_if
//
// Purpose:
//   Bundles the two handshaked channels of the TLB/MMU block:
//     - the translation channel (request from a core, response back to it)
//     - the page-table-walk channel (walk request out to memory, PTE back)
//
// Modports:
//   master : the requester/memory side (drives translation requests, accepts
//            responses, serves page-table reads)
//   slave  : the MMU itself (accepts translation requests, returns
//            responses, issues page-table reads)
//
// Signals (ADDR_WIDTH wide unless noted):
//   mmu_req_valid/ready (1), mmu_req_va, mmu_req_write (1)
//   mmu_resp_valid/ready (1), mmu_resp_pa, mmu_resp_status (2)
//   ptw_req_valid/ready (1), ptw_req_addr
//   ptw_resp_valid (1), ptw_resp_data (PTE)
// -----------------------------------------------------------------------------
interface param_tlb_mmu_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mmu_req_valid;
    logic [ADDR_WIDTH-1:0] mmu_req_va;
    logic                  mmu_req_write;
    logic                  mmu_req_ready;

    logic                  mmu_resp_valid;
    logic [ADDR_WIDTH-1:0] mmu_resp_pa;
    logic [1:0]            mmu_resp_status;
    logic                  mmu_resp_ready;

    logic                  ptw_req_valid;
    logic [ADDR_WIDTH-1:0] ptw_req_addr;
    logic                  ptw_req_ready;
    logic                  ptw_resp_valid;
    logic [ADDR_WIDTH-1:0] ptw_resp_data;

    // Requester / page-table memory view
    modport master (
        output mmu_req_valid,
        output mmu_req_va,
        output mmu_req_write,
        input  mmu_req_ready,
        input  mmu_resp_valid,
        input  mmu_resp_pa,
        input  mmu_resp_status,
        output mmu_resp_ready,
        input  ptw_req_valid,
        input  ptw_req_addr,
        output ptw_req_ready,
        output ptw_resp_valid,
        output ptw_resp_data
    );

    // MMU view
    modport slave (
        input  mmu_req_valid,
        input  mmu_req_va,
        input  mmu_req_write,
        output mmu_req_ready,
        output mmu_resp_valid,
        output mmu_resp_pa,
        output mmu_resp_status,
        input  mmu_resp_ready,
        output ptw_req_valid,
        output ptw_req_addr,
        input  ptw_req_ready,
        input  ptw_resp_valid,
        input  ptw_resp_data
    );
endinterface

// File: rtl/param_tlb_mmu.sv
// -----------------------------------------------------------------------------
// param_tlb_mmu
//
// Purpose:
//   Fully-associative TLB in front of a single-level page table. Hits are
//   answered one cycle after acceptance; misses launch a page-table walk to
//   PT_BASE + VPN*4, install a valid PTE (LRU-by-age victim) and answer with
//   status MISS. Invalid PTEs give PAGE_FAULT, stores to read-only pages give
//   PERM_FAULT (PA forced to 0).
//
// Ports:
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset
//   tlb_flush  : invalidates every entry at the next edge (ages untouched)
//   bus        : param_tlb_mmu_if.slave (translation + walk channels)
//
// Status encoding: 00 HIT, 01 MISS, 10 PAGE_FAULT, 11 PERM_FAULT
// PTE layout     : bit0 V, bit1 W, [ADDR_WIDTH-1:PAGE_OFFSET_WIDTH] PFN
// -----------------------------------------------------------------------------
module param_tlb_mmu #(
    parameter int                    ADDR_WIDTH        = 32,
    parameter int                    PAGE_OFFSET_WIDTH = 12,
    parameter int                    NUM_ENTRIES       = 8,
    parameter logic [ADDR_WIDTH-1:0] PT_BASE           = 'h0000_1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tlb_flush,
    param_tlb_mmu_if.slave       bus
);

    localparam int VW = ADDR_WIDTH - PAGE_OFFSET_WIDTH;
    localparam int IW = $clog2(NUM_ENTRIES);

    localparam logic [1:0] ST_HIT        = 2'b00;
    localparam logic [1:0] ST_MISS       = 2'b01;
    localparam logic [1:0] ST_PAGE_FAULT = 2'b10;
    localparam logic [1:0] ST_PERM_FAULT = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        PTW_REQ,
        PTW_WAIT
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;

    logic [NUM_ENTRIES-1:0]  r_valid;
    logic [NUM_ENTRIES-1:0]  r_writable;
    logic [VW-1:0]           r_vpn [NUM_ENTRIES];
    logic [VW-1:0]           r_pfn [NUM_ENTRIES];
    logic [IW-1:0]           r_age [NUM_ENTRIES];

    logic [ADDR_WIDTH-1:0]   r_reqVa;
    logic                    r_reqWrite;
    logic                    r_flushPending;

    logic                    r_respValid;
    logic [ADDR_WIDTH-1:0]   r_respPa;
    logic [1:0]              r_respStatus;
    logic [ADDR_WIDTH-1:0]   r_ptwReqAddr;

    logic [VW-1:0]           w_reqVpn;
    logic                    w_reqReady;
    logic                    w_accept;
    logic                    w_lookupHit;
    logic [IW-1:0]           w_hitIdx;
    logic                    w_anyInvalid;
    logic [IW-1:0]           w_victimIdx;
    logic                    w_walkDone;
    logic                    w_pteValid;
    logic                    w_pteWritable;
    logic [VW-1:0]           w_ptePfn;
    logic                    w_install;
    logic                    w_touch;
    logic [IW-1:0]           w_touchIdx;
    logic [IW-1:0]           w_touchAge;
    logic [ADDR_WIDTH-1:0]   w_ptAddr;
    logic                    w_ptwReqValid;
    logic [PAGE_OFFSET_WIDTH-3:0] w_unusedPteBits;

    // Request-side decode. New requests are refused while a response is
    // still waiting to be taken, during a walk, and in a flush cycle so a
    // lookup never races the invalidation.
    assign w_reqVpn   = bus.mmu_req_va[ADDR_WIDTH-1:PAGE_OFFSET_WIDTH];
    assign w_reqReady = (r_state == IDLE) && !r_respValid && !tlb_flush;
    assign w_accept   = bus.mmu_req_valid && w_reqReady;

    // Page-table entry address; the shift and add wrap at ADDR_WIDTH bits.
    assign w_ptAddr = PT_BASE + ({{PAGE_OFFSET_WIDTH{1'b0}}, w_reqVpn} << 2);

    // PTE decode. Only meaningful while a walk result is on the bus.
    assign w_walkDone      = (r_state == PTW_WAIT) && bus.ptw_resp_valid;
    assign w_pteValid      = bus.ptw_resp_data[0];
    assign w_pteWritable   = bus.ptw_resp_data[1];
    assign w_ptePfn        = bus.ptw_resp_data[ADDR_WIDTH-1:PAGE_OFFSET_WIDTH];
    assign w_unusedPteBits = bus.ptw_resp_data[PAGE_OFFSET_WIDTH-1:2];

    // A walk result is installed only if no flush arrived while it was in
    // flight (or in the very cycle it returns).
    assign w_install = w_walkDone && w_pteValid && !r_flushPending && !tlb_flush;

    // Associative lookup of the incoming VPN. Install happens only after a
    // miss, so at most one valid entry can match.
    always_comb begin
        w_lookupHit = 1'b0;
        w_hitIdx    = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (r_valid[i] && (r_vpn[i] == w_reqVpn)) begin
                w_lookupHit = 1'b1;
                w_hitIdx    = IW'(i);
            end
        end
    end

    // Victim choice: lowest-index free slot, otherwise the oldest entry.
    // Ages form a permutation, so exactly one entry holds the maximum age.
    always_comb begin
        w_anyInvalid = 1'b0;
        w_victimIdx  = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_anyInvalid = 1'b1;
                w_victimIdx  = IW'(i);
            end
        end
        if (!w_anyInvalid) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (r_age[i] == IW'(NUM_ENTRIES - 1)) begin
                    w_victimIdx = IW'(i);
                end
            end
        end
    end

    // The entry touched this cycle (hit or install) for the age update.
    // Hits are only accepted in IDLE and installs only occur in PTW_WAIT,
    // so the two never coincide.
    assign w_touch    = (w_accept && w_lookupHit) || w_install;
    assign w_touchIdx = w_install ? w_victimIdx : w_hitIdx;
    assign w_touchAge = r_age[w_touchIdx];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state and walk-request strobe. Hits never leave IDLE.
    always_comb begin
        w_nextState   = r_state;
        w_ptwReqValid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_lookupHit) begin
                    w_nextState = PTW_REQ;
                end
            end
            PTW_REQ: begin
                w_ptwReqValid = 1'b1;
                if (bus.ptw_req_ready) begin
                    w_nextState = PTW_WAIT;
                end
            end
            PTW_WAIT: begin
                if (bus.ptw_resp_valid) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Request capture, walk address and response registers. The response
    // stays frozen until the requester takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reqVa      <= '0;
            r_reqWrite   <= 1'b0;
            r_ptwReqAddr <= '0;
            r_respValid  <= 1'b0;
            r_respPa     <= '0;
            r_respStatus <= ST_HIT;
        end else begin
            if (r_respValid && bus.mmu_resp_ready) begin
                r_respValid <= 1'b0;
            end
            if (w_accept) begin
                if (w_lookupHit) begin
                    r_respValid <= 1'b1;
                    if (bus.mmu_req_write && !r_writable[w_hitIdx]) begin
                        r_respPa     <= '0;
                        r_respStatus <= ST_PERM_FAULT;
                    end else begin
                        r_respPa     <= {r_pfn[w_hitIdx], bus.mmu_req_va[PAGE_OFFSET_WIDTH-1:0]};
                        r_respStatus <= ST_HIT;
                    end
                end else begin
                    r_reqVa      <= bus.mmu_req_va;
                    r_reqWrite   <= bus.mmu_req_write;
                    r_ptwReqAddr <= w_ptAddr;
                end
            end
            if (w_walkDone) begin
                r_respValid <= 1'b1;
                if (!w_pteValid) begin
                    r_respPa     <= '0;
                    r_respStatus <= ST_PAGE_FAULT;
                end else if (r_reqWrite && !w_pteWritable) begin
                    r_respPa     <= '0;
                    r_respStatus <= ST_PERM_FAULT;
                end else begin
                    r_respPa     <= {w_ptePfn, r_reqVa[PAGE_OFFSET_WIDTH-1:0]};
                    r_respStatus <= ST_MISS;
                end
            end
        end
    end

    // Remember a flush seen while a walk is in flight; it is forgotten once
    // the FSM is back in IDLE, before the next walk can start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flushPending <= 1'b0;
        end else if (tlb_flush && (r_state != IDLE)) begin
            r_flushPending <= 1'b1;
        end else if (r_state == IDLE) begin
            r_flushPending <= 1'b0;
        end
    end

    // TLB array: install on a successful walk, bulk invalidate on flush.
    // Flush is listed last so it wins over anything else in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= '0;
            r_writable <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_vpn[i] <= '0;
                r_pfn[i] <= '0;
            end
        end else begin
            if (w_install) begin
                r_valid[w_victimIdx]    <= 1'b1;
                r_writable[w_victimIdx] <= w_pteWritable;
                r_vpn[w_victimIdx]      <= r_reqVa[ADDR_WIDTH-1:PAGE_OFFSET_WIDTH];
                r_pfn[w_victimIdx]      <= w_ptePfn;
            end
            if (tlb_flush) begin
                r_valid <= '0;
            end
        end
    end

    // Recency ages. The touched entry becomes youngest and everything that
    // was younger than it ages by one, which keeps the set a permutation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_age[i] <= IW'(i);
            end
        end else if (w_touch) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (IW'(i) == w_touchIdx) begin
                    r_age[i] <= '0;
                end else if (r_age[i] < w_touchAge) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end

    assign bus.mmu_req_ready   = w_reqReady;
    assign bus.mmu_resp_valid  = r_respValid;
    assign bus.mmu_resp_pa     = r_respPa;
    assign bus.mmu_resp_status = r_respStatus;
    assign bus.ptw_req_valid   = w_ptwReqValid;
    assign bus.ptw_req_addr    = r_ptwReqAddr;

endmodule
